// File: rtl/shift_sched_pkg.sv
// Shared definitions for the shift scheduler: FSM state encoding and width helpers.
package shift_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Largest shift amount encodable in a sw-bit field.
  function automatic int max_shift(input int sw);
    return (1 << sw) - 1;
  endfunction

endpackage

// File: rtl/shift_sched_shift1_reg.sv
// Registered accumulator with load, shift-left-by-one and hold; load wins over shift.
module shift1_reg #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] d_in,
  input  logic         en,
  output logic [W-1:0] q
);

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      q <= '0;
    end else if (load) begin
      q <= d_in;
    end else if (en) begin
      q <= {q[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/shift_sched.sv
// Round-robin scheduler that multiplexes requesters onto one iterative shift-by-one datapath.
module shift_sched
  import shift_sched_pkg::*;
#(
  parameter  int DW    = 4,
  parameter  int SW    = 2,
  parameter  int NREQ  = 2,
  localparam int MAXSH = max_shift(SW),
  localparam int OW    = DW + MAXSH,
  localparam int IW    = $clog2(NREQ)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ*SW-1:0] req_amt,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  output logic [OW-1:0]      q,
  output logic               q_valid,
  output logic [IW-1:0]      q_id,
  input  logic               q_ready
);

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [SW-1:0]   cnt;
  logic [IW-1:0]   win;
  logic            found;
  logic [DW-1:0]   win_data;
  logic [SW-1:0]   win_amt;
  logic            take;
  logic            shift_en;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    int idx;
    idx   = 0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  assign win_data = req_data[win*DW +: DW];
  assign win_amt  = req_amt[win*SW +: SW];

  // Outputs are gated by reset_n so they read 0 throughout reset, even before the first edge.
  assign take     = reset_n && (state == ST_IDLE) && found;
  assign gnt      = take ? (NREQ'(1) << win) : '0;
  assign busy     = reset_n && (state != ST_IDLE);
  assign q_valid  = reset_n && (state == ST_DONE);
  assign shift_en = (state == ST_SHIFT);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (found) state_nxt = (win_amt == '0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (cnt == SW'(1)) state_nxt = ST_DONE;
      ST_DONE:  if (q_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      cnt    <= '0;
      q_id   <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        cnt    <= win_amt;
        q_id   <= win;
        rr_ptr <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
      end else if (shift_en) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Zero-extended operand: MAXSH spare MSBs guarantee no bit falls off the top.
  shift1_reg #(.W(OW)) u_acc (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (take),
    .d_in    ({{MAXSH{1'b0}}, win_data}),
    .en      (shift_en),
    .q       (q)
  );

endmodule

// File: tb/tb_shift_sched.sv
// Directed self-checking bench for shift_sched with hand-computed expected values.
module tb_shift_sched;

  logic       clock;
  logic       reset_n;
  logic [1:0] req;
  logic [7:0] req_data;
  logic [3:0] req_amt;
  logic [1:0] gnt;
  logic       busy;
  logic [6:0] q;
  logic       q_valid;
  logic [0:0] q_id;
  logic       q_ready;

  int n_checks = 0;
  int n_fail   = 0;

  shift_sched #(.DW(4), .SW(2), .NREQ(2)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req      (req),
    .req_data (req_data),
    .req_amt  (req_amt),
    .gnt      (gnt),
    .busy     (busy),
    .q        (q),
    .q_valid  (q_valid),
    .q_id     (q_id),
    .q_ready  (q_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Steps until q_valid rises (bounded) and checks the cycle count after the gnt cycle.
  task automatic wait_valid(input string tag, input int exp_lat);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!q_valid && n < 12);
    check({tag, "_latency"}, n, exp_lat);
  endtask

  task automatic ack(input string tag);
    q_ready = 1'b1;
    step();
    check({tag, "_valid_after_ack"}, q_valid, 0);
    check({tag, "_busy_after_ack"}, busy, 0);
  endtask

  task automatic run_job(input string tag, input logic [1:0] exp_gnt, input int exp_lat,
                         input logic [6:0] exp_q, input int exp_id);
    #1;
    check({tag, "_gnt"}, gnt, exp_gnt);
    wait_valid(tag, exp_lat);
    check({tag, "_q"}, q, exp_q);
    check({tag, "_q_id"}, q_id, exp_id);
    check({tag, "_busy"}, busy, 1);
    ack(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // 1. Reset with both requests asserted.
    reset_n  = 1'b0;
    req      = 2'b11;
    req_data = 8'h00;
    req_amt  = 4'h0;
    q_ready  = 1'b0;
    #1;
    check("rst_gnt_pre_edge", gnt, 0);
    repeat (3) step();
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_q_valid", q_valid, 0);
    check("rst_q", q, 0);
    check("rst_q_id", q_id, 0);

    // No requests in IDLE: stay idle.
    reset_n = 1'b1;
    req     = 2'b00;
    step();
    check("idle_no_req_busy", busy, 0);
    check("idle_no_req_gnt", gnt, 0);

    // 2. Requester 0: 4'b1011 << 2 = 7'h2C.
    req      = 2'b01;
    req_data = {4'h0, 4'b1011};
    req_amt  = {2'd0, 2'd2};
    run_job("t2", 2'b01, 3, 7'h2C, 0);
    q_ready = 1'b0;

    // 3. Requester 1: 4'hF << 0 = 7'h0F.
    req      = 2'b10;
    req_data = {4'hF, 4'h0};
    req_amt  = {2'd0, 2'd0};
    run_job("t3", 2'b10, 1, 7'h0F, 1);
    q_ready = 1'b0;

    // 4. Both held: alternating grants; 1001<<3 = 7'h48, 0110<<3 = 7'h30.
    req      = 2'b11;
    q_ready  = 1'b1;
    req_data = {4'b0110, 4'b1001};
    req_amt  = {2'd3, 2'd3};
    for (int j = 0; j < 4; j++) begin
      if (j % 2 == 0) run_job($sformatf("t4_job%0d", j), 2'b01, 4, 7'h48, 0);
      else            run_job($sformatf("t4_job%0d", j), 2'b10, 4, 7'h30, 1);
    end

    // 5. Stall in DONE with requests pending: 1011<<1 = 7'h16.
    q_ready  = 1'b0;
    req      = 2'b01;
    req_data = {4'b0110, 4'b1011};
    req_amt  = {2'd3, 2'd1};
    #1;
    check("t5_gnt", gnt, 2'b01);
    wait_valid("t5", 2);
    req = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("t5_hold%0d_valid", i), q_valid, 1);
      check($sformatf("t5_hold%0d_q", i), q, 7'h16);
      check($sformatf("t5_hold%0d_q_id", i), q_id, 0);
      check($sformatf("t5_hold%0d_gnt", i), gnt, 0);
      check($sformatf("t5_hold%0d_busy", i), busy, 1);
      step();
    end
    ack("t5");
    q_ready = 1'b0;

    // 6. Reset mid-SHIFT; the held request is granted again after release.
    req = 2'b10;
    #1;
    check("t6_gnt", gnt, 2'b10);
    step();
    step();
    check("t6_busy_mid_shift", busy, 1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_valid", q_valid, 0);
    check("t6_rst_gnt", gnt, 0);
    step();
    reset_n = 1'b1;
    #1;
    check("t6_post_rst_busy", busy, 0);
    check("t6_post_rst_valid", q_valid, 0);
    check("t6_post_rst_q", q, 0);
    run_job("t6_regrant", 2'b10, 4, 7'h30, 1);
    q_ready = 1'b0;
    req     = 2'b00;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
